iob_cache_write_buffer: RTL

IOB_CACHE_WRITE_BUFFER -- requirements
Module: iob_cache_write_buffer

---
 rtl/iob_cache_write_buffer_pkg.sv | 12 +
 rtl/iob_cache_write_buffer_mem.sv | 33 +++
 rtl/iob_cache_write_buffer.sv | 95 +++++++++
 3 files changed

// File: rtl/iob_cache_write_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : iob_cache_write_buffer_pkg
// Brief   : Shared default widths for the cache write buffer.
// Revision: 1.0
// ============================================================================
package iob_cache_write_buffer_pkg;
    localparam int IOB_CACHE_ADDR_W  = 32;
    localparam int IOB_CACHE_DATA_W  = 32;
    localparam int IOB_CACHE_WBUF_DEPTH_W = 2;
endpackage
`default_nettype wire

// File: rtl/iob_cache_write_buffer_mem.sv
`default_nettype none
// ============================================================================
// Module  : iob_cache_wbuf_mem
// Brief   : Entry register array, one synchronous write port, one async read.
// Revision: 1.0
// ============================================================================
module iob_cache_wbuf_mem
    import iob_cache_write_buffer_pkg::*;
#(
    parameter int DEPTH_W = IOB_CACHE_WBUF_DEPTH_W,
    parameter int WIDTH   = 64
) (
    input  logic               clk_i,
    input  logic               w_en_i,
    input  logic [DEPTH_W-1:0] w_addr_i,
    input  logic [WIDTH-1:0]   w_data_i,
    input  logic [DEPTH_W-1:0] r_addr_i,
    output logic [WIDTH-1:0]   r_data_o
);
    localparam int DEPTH = 1 << DEPTH_W;

    // Storage is intentionally left unreset; readers gate it with valid.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (w_en_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_addr_i];
endmodule
`default_nettype wire

// File: rtl/iob_cache_write_buffer.sv
`default_nettype none
// ============================================================================
// Module  : iob_cache_write_buffer
// Brief   : Show-ahead FIFO between cache front-end writes and back-end channel.
// Revision: 1.0
// ============================================================================
module iob_cache_write_buffer
    import iob_cache_write_buffer_pkg::*;
#(
    parameter int ADDR_W  = IOB_CACHE_ADDR_W,
    parameter int DATA_W  = IOB_CACHE_DATA_W,
    parameter int DEPTH_W = IOB_CACHE_WBUF_DEPTH_W,
    localparam int NBYTES   = DATA_W / 8,
    localparam int NBYTES_W = $clog2(NBYTES),
    localparam int WADDR_W  = ADDR_W - NBYTES_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_valid_i,
    input  logic [WADDR_W-1:0]  wr_addr_i,
    input  logic [DATA_W-1:0]   wr_wdata_i,
    input  logic [NBYTES-1:0]   wr_wstrb_i,
    output logic                wr_ready_o,
    output logic                write_valid_o,
    output logic [WADDR_W-1:0]  write_addr_o,
    output logic [DATA_W-1:0]   write_wdata_o,
    output logic [NBYTES-1:0]   write_wstrb_o,
    input  logic                write_ready_i,
    output logic                empty_o,
    output logic                full_o,
    output logic [DEPTH_W:0]    level_o
);
    localparam int ENTRY_W = WADDR_W + DATA_W + NBYTES;
    localparam logic [DEPTH_W:0] MAX_LEVEL = (DEPTH_W + 1)'(1 << DEPTH_W);

    logic [DEPTH_W-1:0] wptr_q, wptr_d;
    logic [DEPTH_W-1:0] rptr_q, rptr_d;
    logic [DEPTH_W:0]   level_q, level_d;
    logic               push, pop;
    logic [ENTRY_W-1:0] head_entry;

    // Flags come from the level register only, so no input reaches them.
    assign empty_o       = (level_q == '0);
    assign full_o        = (level_q == MAX_LEVEL);
    assign level_o       = level_q;
    assign wr_ready_o    = !full_o;
    assign write_valid_o = !empty_o;

    assign push = wr_valid_i && wr_ready_o;
    assign pop  = write_valid_o && write_ready_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push) begin
            wptr_d = wptr_q + DEPTH_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + DEPTH_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    iob_cache_wbuf_mem #(
        .DEPTH_W (DEPTH_W),
        .WIDTH   (ENTRY_W)
    ) u_mem (
        .clk_i    (clk_i),
        .w_en_i   (push),
        .w_addr_i (wptr_q),
        .w_data_i ({wr_addr_i, wr_wdata_i, wr_wstrb_i}),
        .r_addr_i (rptr_q),
        .r_data_o (head_entry)
    );

    assign {write_addr_o, write_wdata_o, write_wstrb_o} = head_entry;
endmodule
`default_nettype wire
